// File: rtl/uart_wb_pkg.sv
// Shared register map, bit positions and FSM state type for the UART Wishbone TX feeder.
package uart_wb_pkg;

    localparam int REG_RB_TR = 0;
    localparam int REG_IE    = 1;
    localparam int REG_LC    = 3;
    localparam int REG_LS    = 5;
    localparam int REG_DL1   = 0;
    localparam int REG_DL2   = 1;

    localparam int LSR_THRE  = 5;
    localparam int DLAB      = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_LCR_DLAB,
        ST_W_DL1,
        ST_W_DL2,
        ST_W_LCR,
        ST_READY,
        ST_POLL,
        ST_W_THR,
        ST_ERROR
    } feeder_state_e;

    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/uart_wb_tx_feeder_if.sv
// Wishbone master/slave signal bundle between the feeder and the UART register file.
interface uart_wb_tx_feeder_if #(
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] wb_adr_o;
    logic [31:0]       wb_dat_o;
    logic [31:0]       wb_dat_i;
    logic              wb_we_o;
    logic              wb_stb_o;
    logic              wb_cyc_o;
    logic [3:0]        wb_sel_o;
    logic              wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/uart_wb_single_xfer.sv
// Single-transfer Wishbone engine: byte-lane placement, sel generation, ack timeout.
// Bus outputs are registered, so the cycle after an ack is always idle.
module uart_wb_single_xfer
    import uart_wb_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [7:0]        wdata,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              timeout,
    output logic              busy,
    uart_wb_tx_feeder_if.master wb
);

    localparam logic [15:0] TMO_LOAD = 16'(ACK_TIMEOUT - 1);

    logic [15:0] tmo_cnt;

    // Results are suppressed during reset so a late ack cannot leak a completion.
    assign done    = wb.wb_cyc_o & wb.wb_ack_i & ~rst;
    assign timeout = wb.wb_cyc_o & ~wb.wb_ack_i & (tmo_cnt == 16'd0) & ~rst;
    assign busy    = wb.wb_cyc_o;
    assign rdata   = 8'(wb.wb_dat_i >> {wb.wb_adr_o[1:0], 3'b000});

    always_ff @(posedge clk) begin
        if (rst) begin
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_sel_o <= '0;
            tmo_cnt     <= '0;
        end else if (wb.wb_cyc_o) begin
            if (wb.wb_ack_i || tmo_cnt == 16'd0) begin
                wb.wb_cyc_o <= 1'b0;
                wb.wb_stb_o <= 1'b0;
                wb.wb_we_o  <= 1'b0;
                wb.wb_adr_o <= '0;
                wb.wb_dat_o <= '0;
                wb.wb_sel_o <= '0;
                tmo_cnt     <= '0;
            end else begin
                tmo_cnt <= tmo_cnt - 16'd1;
            end
        end else if (req) begin
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            wb.wb_we_o  <= we;
            wb.wb_adr_o <= adr;
            wb.wb_dat_o <= 32'(wdata) << {adr[1:0], 3'b000};
            wb.wb_sel_o <= lane_sel(adr[1:0]);
            tmo_cnt     <= TMO_LOAD;
        end
    end

endmodule

// File: rtl/uart_wb_tx_feeder.sv
// Wishbone master that configures a 16550-style UART and streams bytes into its THR,
// polling LSR.THRE once per FIFO_DEPTH bytes.
//
// state      | meaning
// IDLE       | waiting for cfg_start
// W_LCR_DLAB | write LCR with DLAB set
// W_DL1      | write divisor low byte
// W_DL2      | write divisor high byte
// W_LCR      | write LCR with DLAB clear
// READY      | configured, waiting for a byte
// POLL       | reading LSR until THRE is seen
// W_THR      | writing one byte to THR
// ERROR      | ack timeout, waiting for cfg_start
module uart_wb_tx_feeder
    import uart_wb_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int ACK_TIMEOUT = 255,
    parameter int ADDR_W      = 5
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        cfg_start,
    input  logic [15:0] cfg_div,
    input  logic [7:0]  cfg_lcr,
    output logic        cfg_done,
    output logic        err,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    uart_wb_tx_feeder_if.master wb
);

    localparam logic [7:0] DLAB_MASK = 8'(1 << DLAB);
    localparam logic [7:0] THRE_MASK = 8'(1 << LSR_THRE);
    localparam logic [4:0] CREDIT_LOAD = 5'(FIFO_DEPTH);

    feeder_state_e     state_q, state_d;
    logic [4:0]        credit_q;
    logic [15:0]       div_q;
    logic [7:0]        lcr_q;
    logic              err_q;

    logic              req, we;
    logic [ADDR_W-1:0] adr;
    logic [7:0]        wdata;
    logic              done, timeout, busy;
    logic [7:0]        rdata;
    logic              start_cfg, reload, consume;

    uart_wb_single_xfer #(
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_xfer (
        .clk     (clk),
        .rst     (wb_rst_i),
        .req     (req),
        .we      (we),
        .adr     (adr),
        .wdata   (wdata),
        .done    (done),
        .rdata   (rdata),
        .timeout (timeout),
        .busy    (busy),
        .wb      (wb)
    );

    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        we        = 1'b0;
        adr       = '0;
        wdata     = '0;
        start_cfg = 1'b0;
        reload    = 1'b0;
        consume   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (cfg_start) start_cfg = 1'b1;
            end
            ST_W_LCR_DLAB: begin
                req   = 1'b1;
                we    = 1'b1;
                adr   = ADDR_W'(REG_LC);
                wdata = lcr_q | DLAB_MASK;
                if (done) state_d = ST_W_DL1;
            end
            ST_W_DL1: begin
                req   = 1'b1;
                we    = 1'b1;
                adr   = ADDR_W'(REG_DL1);
                wdata = div_q[7:0];
                if (done) state_d = ST_W_DL2;
            end
            ST_W_DL2: begin
                req   = 1'b1;
                we    = 1'b1;
                adr   = ADDR_W'(REG_DL2);
                wdata = div_q[15:8];
                if (done) state_d = ST_W_LCR;
            end
            ST_W_LCR: begin
                req   = 1'b1;
                we    = 1'b1;
                adr   = ADDR_W'(REG_LC);
                wdata = lcr_q & ~DLAB_MASK;
                if (done) state_d = ST_READY;
            end
            ST_READY: begin
                if (cfg_start) begin
                    start_cfg = 1'b1;
                end else if (s_tvalid) begin
                    state_d = (credit_q == 5'd0) ? ST_POLL : ST_W_THR;
                end
            end
            ST_POLL: begin
                // A read already on the bus completes; new reads start only while a byte waits.
                req = s_tvalid;
                adr = ADDR_W'(REG_LS);
                if (done) begin
                    if ((rdata & THRE_MASK) != 8'd0) begin
                        reload  = 1'b1;
                        state_d = s_tvalid ? ST_W_THR : ST_READY;
                    end
                end else if (!busy && !s_tvalid) begin
                    state_d = ST_READY;
                end
            end
            ST_W_THR: begin
                req   = 1'b1;
                we    = 1'b1;
                adr   = ADDR_W'(REG_RB_TR);
                wdata = s_tdata;
                if (done) begin
                    consume = 1'b1;
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) state_d = ST_ERROR;
        if (start_cfg) state_d = ST_W_LCR_DLAB;
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            credit_q <= 5'd0;
            div_q    <= 16'd0;
            lcr_q    <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_cfg) begin
                div_q    <= cfg_div;
                lcr_q    <= cfg_lcr;
                credit_q <= 5'd0;
                err_q    <= 1'b0;
            end else begin
                if (timeout) err_q <= 1'b1;
                if (reload) begin
                    credit_q <= CREDIT_LOAD;
                end else if (consume && credit_q != 5'd0) begin
                    credit_q <= credit_q - 5'd1;
                end
            end
        end
    end

    assign cfg_done = (state_q == ST_READY) || (state_q == ST_POLL) || (state_q == ST_W_THR);
    assign err      = err_q;
    assign s_tready = (state_q == ST_W_THR) && done;

endmodule

// File: tb/tb_uart_wb_tx_feeder.sv
// Self-checking bench for uart_wb_tx_feeder: behavioural Wishbone UART slave plus a
// transaction-level model of the expected configuration and streaming traffic.
module tb_uart_wb_tx_feeder;
    import uart_wb_pkg::*;

    localparam int ADDR_W      = 5;
    localparam int FIFO_DEPTH  = 16;
    localparam int ACK_TIMEOUT = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic              we;
        logic [3:0]        sel;
        logic [31:0]       dat;
    } txn_t;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_div = 16'd0;
    logic [7:0]  cfg_lcr = 8'd0;
    logic        cfg_done, err;
    logic [7:0]  s_tdata = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;

    uart_wb_tx_feeder_if #(.ADDR_W(ADDR_W)) wb ();

    uart_wb_tx_feeder #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .cfg_start (cfg_start),
        .cfg_div   (cfg_div),
        .cfg_lcr   (cfg_lcr),
        .cfg_done  (cfg_done),
        .err       (err),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .wb        (wb)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Slave: registered ack after wait_states cycles; LSR lane 1 carries THRE.
    int          wait_states = 0;
    int          hang_txn = -1;
    int          lsr_clear_target = 0;
    int          lsr_clear_used = 0;
    int          slv_idx = 0;
    int          wcnt = 0;
    logic [31:0] slv_rnd;

    always @(posedge clk) begin
        wb.wb_ack_i <= 1'b0;
        if (wb_rst_i) wb.wb_dat_i <= 32'd0;
        if (!wb.wb_cyc_o) begin
            wcnt <= 0;
        end else if (wb.wb_stb_o && !wb.wb_ack_i) begin
            if (slv_idx != hang_txn && wcnt >= wait_states) begin
                wb.wb_ack_i <= 1'b1;
                slv_idx <= slv_idx + 1;
                wcnt <= 0;
                slv_rnd = $urandom;
                if (!wb.wb_we_o && wb.wb_adr_o == ADDR_W'(REG_LS)) begin
                    if (lsr_clear_used < lsr_clear_target) begin
                        slv_rnd[13] = 1'b0;
                        lsr_clear_used <= lsr_clear_used + 1;
                    end else begin
                        slv_rnd[13] = 1'b1;
                    end
                end
                wb.wb_dat_i <= slv_rnd;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // Bus monitor: logs completed transfers and counts protocol violations.
    txn_t log_q[$];
    txn_t cap, cur;
    int   proto_errs = 0, tready_cnt = 0, cyc_starts = 0, cyc_len = 0, last_cyc_len = 0;
    logic prev_cyc = 1'b0, prev_ack = 1'b0;

    always @(negedge clk) begin
        cur = {wb.wb_adr_o, wb.wb_we_o, wb.wb_sel_o, wb.wb_dat_o};
        if (wb.wb_stb_o !== wb.wb_cyc_o) proto_errs++;
        if (wb.wb_cyc_o) begin
            if (prev_cyc && prev_ack) proto_errs++;
            if (!prev_cyc) begin
                cap = cur;
                cyc_len = 1;
                cyc_starts++;
            end else begin
                cyc_len++;
                if (cur !== cap) proto_errs++;
            end
            if (wb.wb_ack_i) log_q.push_back(cur);
        end else begin
            if (prev_cyc) last_cyc_len = cyc_len;
            if (cur !== '0) proto_errs++;
        end
        if (s_tready) begin
            tready_cnt++;
            if (!(wb.wb_cyc_o && wb.wb_ack_i && wb.wb_we_o && wb.wb_adr_o == ADDR_W'(REG_RB_TR)))
                proto_errs++;
        end
        prev_cyc = wb.wb_cyc_o;
        prev_ack = wb.wb_ack_i;
    end

    // Reference model state: bytes the UART FIFO may still take without a poll.
    int         m_credit = 0;
    logic [7:0] stim_q[$];

    function automatic txn_t exp_wr(int adr, logic [7:0] b);
        txn_t t;
        int lane = adr % 4;
        t.adr = ADDR_W'(adr);
        t.we  = 1'b1;
        t.sel = 4'(1 << lane);
        t.dat = 32'(b) << (8 * lane);
        return t;
    endfunction

    function automatic txn_t exp_rd(int adr);
        txn_t t;
        t.adr = ADDR_W'(adr);
        t.we  = 1'b0;
        t.sel = 4'(1 << (adr % 4));
        t.dat = 32'd0;
        return t;
    endfunction

    task automatic do_config(input logic [15:0] div, input logic [7:0] lcr, output bit ok);
        @(negedge clk);
        cfg_div = div;
        cfg_lcr = lcr;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (cfg_done || err) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        m_credit = 0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_we_o !== 1'b0)
            begin miscompares++; $display("FAIL reset_ctl: got cyc=%b stb=%b we=%b required 000", wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o); end
        vectors++; if (wb.wb_adr_o !== '0 || wb.wb_dat_o !== '0 || wb.wb_sel_o !== '0)
            begin miscompares++; $display("FAIL reset_bus: got adr=%h dat=%h sel=%b required 0", wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o); end
        vectors++; if (s_tready !== 1'b0 || cfg_done !== 1'b0 || err !== 1'b0)
            begin miscompares++; $display("FAIL reset_status: got tready=%b done=%b err=%b required 000", s_tready, cfg_done, err); end
        wb_rst_i = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = 8'h55;
        repeat (10) @(negedge clk);
        s_tvalid = 1'b0;
        vectors++; if (cyc_starts !== 0)
            begin miscompares++; $display("FAIL idle_no_bus: got %0d cycles required 0", cyc_starts); end
    endtask

    task automatic test_config();
        logic [15:0] div;
        logic [7:0]  lcr;
        txn_t        e[$];
        int          acks;
        bit          seen;
        for (int r = 0; r < 3; r++) begin
            div = (r == 0) ? 16'd2 : 16'($urandom);
            lcr = (r == 0) ? 8'h1B : 8'($urandom);
            wait_states = (r == 0) ? 0 : $urandom_range(0, 3);
            log_q.delete();
            @(negedge clk);
            cfg_div = div;
            cfg_lcr = lcr;
            cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
            acks = 0;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                if (wb.wb_cyc_o && wb.wb_ack_i) begin
                    acks++;
                    if (acks == 4) begin
                        vectors++; if (cfg_done !== 1'b0)
                            begin miscompares++; $display("FAIL cfg_done_early: got %b required 0", cfg_done); end
                        @(negedge clk);
                        vectors++; if (cfg_done !== 1'b1)
                            begin miscompares++; $display("FAIL cfg_done_rise: got %b required 1", cfg_done); end
                        seen = 1'b1;
                    end
                end
                if (!seen) @(negedge clk);
            end
            vectors++; if (!seen)
                begin miscompares++; $display("FAIL cfg_timeout: got %0d acks required 4", acks); end
            e.delete();
            e.push_back(exp_wr(REG_LC, lcr | 8'h80));
            e.push_back(exp_wr(REG_DL1, div[7:0]));
            e.push_back(exp_wr(REG_DL2, div[15:8]));
            e.push_back(exp_wr(REG_LC, lcr & 8'h7F));
            @(negedge clk);
            vectors++; if (log_q.size() != 4)
                begin miscompares++; $display("FAIL cfg_count: got %0d required 4", log_q.size()); end
            for (int k = 0; k < 4 && k < log_q.size(); k++) begin
                vectors++; if (log_q[k] !== e[k])
                    begin miscompares++; $display("FAIL cfg_write%0d: got %h required %h", k, log_q[k], e[k]); end
            end
        end
        m_credit = 0;
        wait_states = 0;
    endtask

    task automatic test_stream(input int clears, input string name);
        txn_t e[$];
        int   t0, gap;
        bit   got;
        log_q.delete();
        t0 = tready_cnt;
        lsr_clear_target = lsr_clear_used + clears;
        foreach (stim_q[k]) begin
            if (m_credit == 0) begin
                repeat (clears + 1) e.push_back(exp_rd(REG_LS));
                clears = 0;
                m_credit = FIFO_DEPTH;
            end
            e.push_back(exp_wr(REG_RB_TR, stim_q[k]));
            m_credit--;
        end
        @(negedge clk);
        foreach (stim_q[k]) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                s_tvalid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            s_tdata = stim_q[k];
            s_tvalid = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (s_tready) begin
                    got = 1'b1;
                    break;
                end
            end
            vectors++; if (!got)
                begin miscompares++; $display("FAIL %s_tready_wait: byte %0d got no accept required accept", name, k); end
        end
        s_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (log_q.size() != e.size())
            begin miscompares++; $display("FAIL %s_txn_count: got %0d required %0d", name, log_q.size(), e.size()); end
        for (int k = 0; k < e.size() && k < log_q.size(); k++) begin
            vectors++;
            if (log_q[k].adr !== e[k].adr || log_q[k].we !== e[k].we || log_q[k].sel !== e[k].sel ||
                (e[k].we && log_q[k].dat !== e[k].dat))
                begin miscompares++; $display("FAIL %s_txn%0d: got %h required %h", name, k, log_q[k], e[k]); end
        end
        vectors++; if (tready_cnt - t0 != stim_q.size())
            begin miscompares++; $display("FAIL %s_tready_count: got %0d required %0d", name, tready_cnt - t0, stim_q.size()); end
    endtask

    task automatic count_log(output int reads, output int writes);
        reads = 0;
        writes = 0;
        foreach (log_q[k]) begin
            if (!log_q[k].we && log_q[k].adr == ADDR_W'(REG_LS)) reads++;
            if (log_q[k].we && log_q[k].adr == ADDR_W'(REG_RB_TR)) writes++;
        end
    endtask

    task automatic test_loopback();
        int rd, wr;
        stim_q = '{8'h81, 8'h42};
        wait_states = 0;
        test_stream(0, "loopback");
        count_log(rd, wr);
        vectors++; if (rd != 1 || wr != 2)
            begin miscompares++; $display("FAIL loopback_mix: got %0d reads %0d writes required 1 and 2", rd, wr); end
        vectors++; if (log_q.size() < 3 || log_q[0].we !== 1'b0 || log_q[2].dat[7:0] !== 8'h42)
            begin miscompares++; $display("FAIL loopback_order: got %0d txns required read,0x81,0x42", log_q.size()); end
    endtask

    task automatic test_lsr_poll();
        int rd, wr;
        bit ok;
        do_config(16'($urandom), 8'($urandom), ok);
        vectors++; if (!ok)
            begin miscompares++; $display("FAIL poll_cfg: got no cfg_done required cfg_done"); end
        stim_q = '{8'($urandom)};
        wait_states = $urandom_range(0, 2);
        test_stream(3, "lsr_poll");
        count_log(rd, wr);
        vectors++; if (rd != 4 || wr != 1)
            begin miscompares++; $display("FAIL lsr_poll_mix: got %0d reads %0d writes required 4 and 1", rd, wr); end
    endtask

    task automatic test_twenty();
        int rd, wr;
        bit ok;
        do_config(16'd2, 8'h1B, ok);
        vectors++; if (!ok)
            begin miscompares++; $display("FAIL twenty_cfg: got no cfg_done required cfg_done"); end
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(8'($urandom));
        wait_states = $urandom_range(0, 3);
        test_stream(0, "twenty");
        count_log(rd, wr);
        vectors++; if (rd != 2 || wr != 20)
            begin miscompares++; $display("FAIL twenty_mix: got %0d reads %0d writes required 2 and 20", rd, wr); end
        wait_states = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        wait_states = 0;
        hang_txn = slv_idx + 1;
        do_config(16'h0123, 8'h03, ok);
        repeat (2) @(negedge clk);
        vectors++; if (!ok || err !== 1'b1)
            begin miscompares++; $display("FAIL tmo_err: got err=%b required 1", err); end
        vectors++; if (cfg_done !== 1'b0)
            begin miscompares++; $display("FAIL tmo_done: got %b required 0", cfg_done); end
        vectors++; if (last_cyc_len != ACK_TIMEOUT)
            begin miscompares++; $display("FAIL tmo_len: got %0d cycles required %0d", last_cyc_len, ACK_TIMEOUT); end
        hang_txn = -1;
        repeat (5) @(negedge clk);
        vectors++; if (err !== 1'b1 || wb.wb_cyc_o !== 1'b0)
            begin miscompares++; $display("FAIL tmo_sticky: got err=%b cyc=%b required 1 0", err, wb.wb_cyc_o); end
        do_config(16'h0123, 8'h03, ok);
        vectors++; if (!ok || err !== 1'b0 || cfg_done !== 1'b1)
            begin miscompares++; $display("FAIL tmo_recover: got err=%b done=%b required 0 1", err, cfg_done); end
    endtask

    task automatic test_reset_mid();
        int  t0, s0;
        bit  seen;
        stim_q = '{8'($urandom)};
        test_stream(0, "pre_reset");
        wait_states = 6;
        @(negedge clk);
        s_tdata = 8'hA5;
        s_tvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wb.wb_cyc_o && wb.wb_we_o) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++; if (!seen)
            begin miscompares++; $display("FAIL mid_thr_start: got no THR cycle required one"); end
        wb_rst_i = 1'b1;
        @(negedge clk);
        vectors++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_we_o !== 1'b0 ||
                       wb.wb_adr_o !== '0 || wb.wb_dat_o !== '0 || wb.wb_sel_o !== '0)
            begin miscompares++; $display("FAIL mid_bus: got cyc=%b adr=%h dat=%h sel=%b required 0", wb.wb_cyc_o, wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o); end
        vectors++; if (s_tready !== 1'b0 || cfg_done !== 1'b0)
            begin miscompares++; $display("FAIL mid_status: got tready=%b done=%b required 0 0", s_tready, cfg_done); end
        wb_rst_i = 1'b0;
        t0 = tready_cnt;
        s0 = cyc_starts;
        repeat (30) @(negedge clk);
        vectors++; if (cyc_starts != s0 || tready_cnt != t0)
            begin miscompares++; $display("FAIL mid_quiet: got %0d cycles %0d accepts required 0 0", cyc_starts - s0, tready_cnt - t0); end
        s_tvalid = 1'b0;
        wait_states = 0;
        m_credit = 0;
    endtask

    task automatic test_protocol();
        vectors++; if (proto_errs != 0)
            begin miscompares++; $display("FAIL bus_protocol: got %0d violations required 0", proto_errs); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_config();
        test_loopback();
        test_lsr_poll();
        test_twenty();
        test_timeout();
        test_reset_mid();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
